unidad_busqueda_instrucciones: RTL and testbench
================================================

# unidad_busqueda_instrucciones

Instruction-fetch sequencer for the pipeline front end. Generates the 10-bit word address into the synchronous instruction ROM (one-cycle read latency), pairs each returned word with its PC, and hands it to the IF/ID stage with a valid flag. Honours stalls from the hazard detection unit and jump/branch redirects, and stops fetching on HLT (32'h00000001).

## Interface
- ADDR_W, 10, word-address width (ROM depth 2^ADDR_W)
- DATA_W, 32, instruction width
- RESET_VECTOR, 0, first fetch address after `start`
- HLT_CODE, 32'h00000001, halt opcode word
- clk  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins fetching at RESET_VECTOR from IDLE or HALTED
- stall  in  1  HDU stall; hold the currently presented instruction
- redirect  in  1  jump/branch taken this cycle
- redirect_target  in  ADDR_W  new fetch address
- direccion  out  ADDR_W  ROM address, combinational
- instruccion  in  DATA_W  ROM data, valid one cycle after address
- inst_out  out  DATA_W  instruction to IF/ID, equals `instruccion`
- pc_out  out  ADDR_W  address of `inst_out`
- inst_valid  out  1  `inst_out` is architecturally valid this cycle
- halted  out  1  controller in HALTED
- instr_count  out  16  instructions delivered since `start`, saturating

## Operation
- States: IDLE (after reset), FETCH, HALTED.
- Registers: `pc_fetch` (next address), `pc_pend` (address of word on `instruccion`), `pend_valid`.
- `direccion` mux, by priority: redirect → `redirect_target`; stall → `pc_pend`; else `pc_fetch`.
- `inst_valid` = FETCH & `pend_valid` & !`redirect`. The word presented in a redirect cycle is wrong-path and is squashed.
- IDLE/HALTED: `start` loads `pc_pend`←RESET_VECTOR, `pc_fetch`←RESET_VECTOR+1, `pend_valid`←1, next FETCH. Without `start`, `direccion`=RESET_VECTOR and `pend_valid`=0.
- FETCH, redirect: `pc_pend`←target, `pc_fetch`←target+1, `pend_valid`←1. Redirect wins over stall and HLT.
- FETCH, stall & !redirect: all registers hold. The ROM re-reads `pc_pend`, so `inst_out` stays stable.
- FETCH, normal: `pc_pend`←`pc_fetch`, `pc_fetch`←`pc_fetch`+1, `pend_valid`←1.
- HLT: if `inst_valid` & !stall & `inst_out`==HLT_CODE, the HLT is delivered once (counted), then next state is HALTED with `pend_valid`←0. A stalled HLT waits until stall drops.
- `instr_count` increments on every `inst_valid` & !stall cycle, saturates at 16'hFFFF, and clears on `start`.
- Address arithmetic is modulo 2^ADDR_W: 1023+1 wraps to 0.
- `start` while in FETCH is ignored.

## Timing
- Reset (async assert, release sync to clk): state IDLE, `pc_fetch`=RESET_VECTOR+1, `pc_pend`=RESET_VECTOR, `pend_valid`=0, `instr_count`=0, `halted`=0, `inst_valid`=0.
- Latency from `start` edge to the first `inst_valid`: one cycle (ROM read).
- Redirect penalty: one squashed cycle. The target instruction is valid the cycle after the redirect.
- Steady state: one instruction per cycle.
- `halted` asserts the cycle after HLT is delivered.
- Reset mid-fetch drops everything immediately; there is no partial delivery.

## Structure
- Shared package `pipeline_pkg`: ADDR_W, DATA_W, HLT_CODE, and the state enum {IDLE, FETCH, HALTED}.
- No sub-module. The ROM `memoriaDeInstrucciones` is instantiated next to this block in the top level, not inside it.

## Test plan
- Reset, then `start` with ROM[0..3]=ADD words → `inst_valid` rises one cycle after `start`; `pc_out` = 0,1,2,3 on consecutive cycles; `instr_count`=4.
- Stall for 3 cycles while `pc_out`=2 → `inst_out`/`pc_out` are held 3 cycles, `instr_count` is unchanged, and fetch resumes at 3.
- Redirect to 12 while `pc_out`=5 → `inst_valid`=0 that cycle, next cycle `pc_out`=12; redirect asserted together with stall also takes effect.
- ROM[16]=HLT → HLT delivered once with `inst_valid`=1, then `halted`=1 and `inst_valid`=0 indefinitely; a later `start` refetches from 0 with `instr_count` cleared.
- Redirect to 1023 → `pc_out` 1023 then 0 (wrap).
- Assert `reset_n`=0 mid-run → all outputs go to reset values asynchronously; with no `start`, the block stays IDLE.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the fetch controller state encoding.
package pipeline_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam logic [31:0] HLT_CODE = 32'h0000_0001;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } estado_t;

endpackage

// File: rtl/unidad_busqueda_instrucciones.sv
// Instruction-fetch sequencer: drives the synchronous ROM address, pairs each
// returned word with its PC, and handles stalls, redirects and HLT.
module unidad_busqueda_instrucciones #(
    parameter int unsigned ADDR_W = pipeline_pkg::ADDR_W,
    parameter int unsigned DATA_W = pipeline_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [DATA_W-1:0] HLT_CODE = pipeline_pkg::HLT_CODE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] direccion,
    input  logic [DATA_W-1:0] instruccion,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              inst_valid,
    output logic              halted,
    output logic [15:0]       instr_count
);

    import pipeline_pkg::*;

    estado_t           estado;
    logic [ADDR_W-1:0] pc_fetch;
    logic [ADDR_W-1:0] pc_pend;
    logic              pend_valid;
    logic              entrega;
    logic              es_hlt;

    assign inst_out   = instruccion;
    assign pc_out     = pc_pend;
    assign halted     = (estado == HALTED);
    assign inst_valid = (estado == FETCH) && pend_valid && !redirect;
    assign entrega    = inst_valid && !stall;
    assign es_hlt     = entrega && (instruccion == HLT_CODE);

    // Outside FETCH the ROM is parked on the reset vector so a start edge
    // finds the first word already addressed.
    always_comb begin
        direccion = RESET_VECTOR;
        if (estado == FETCH) begin
            if (redirect)
                direccion = redirect_target;
            else if (stall)
                direccion = pc_pend;
            else
                direccion = pc_fetch;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado      <= IDLE;
            pc_fetch    <= RESET_VECTOR + 1'b1;
            pc_pend     <= RESET_VECTOR;
            pend_valid  <= 1'b0;
            instr_count <= 16'd0;
        end else begin
            case (estado)
                FETCH: begin
                    if (redirect) begin
                        pc_pend    <= redirect_target;
                        pc_fetch   <= redirect_target + 1'b1;
                        pend_valid <= 1'b1;
                    end else if (!stall) begin
                        if (es_hlt) begin
                            estado     <= HALTED;
                            pend_valid <= 1'b0;
                        end else begin
                            pc_pend    <= pc_fetch;
                            pc_fetch   <= pc_fetch + 1'b1;
                            pend_valid <= 1'b1;
                        end
                    end
                    if (entrega && instr_count != 16'hFFFF)
                        instr_count <= instr_count + 16'd1;
                end
                default: begin
                    pend_valid <= 1'b0;
                    if (start) begin
                        estado      <= FETCH;
                        pc_pend     <= RESET_VECTOR;
                        pc_fetch    <= RESET_VECTOR + 1'b1;
                        pend_valid  <= 1'b1;
                        instr_count <= 16'd0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_busqueda_instrucciones.sv
// Directed self-checking bench for the fetch sequencer with a behavioural ROM.
module tb_unidad_busqueda_instrucciones;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [9:0]  redirect_target;
    logic [9:0]  direccion;
    logic [31:0] instruccion;
    logic [31:0] inst_out;
    logic [9:0]  pc_out;
    logic        inst_valid;
    logic        halted;
    logic [15:0] instr_count;

    logic [31:0] rom [0:1023];
    int compared;
    int mismatched;

    unidad_busqueda_instrucciones dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .stall(stall),
        .redirect(redirect),
        .redirect_target(redirect_target),
        .direccion(direccion),
        .instruccion(instruccion),
        .inst_out(inst_out),
        .pc_out(pc_out),
        .inst_valid(inst_valid),
        .halted(halted),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) instruccion <= rom[direccion];

    // One cycle: inputs change on the falling edge, outputs are observed 1ns later.
    task automatic drive(input logic s, input logic st, input logic rd, input logic [9:0] tgt);
        @(negedge clk);
        start = s;
        stall = st;
        redirect = rd;
        redirect_target = tgt;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        repeat (2) @(negedge clk);
        #1;
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got %b want 0", inst_valid); end
        compared++; if (halted !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_halted got %b want 0", halted); end
        compared++; if (instr_count !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_count got %0d want 0", instr_count); end
        compared++; if (direccion !== 10'd0) begin mismatched++; $display("[TB] FAIL reset_dir got %0d want 0", direccion); end
        compared++; if (pc_out !== 10'd0) begin mismatched++; $display("[TB] FAIL reset_pc got %0d want 0", pc_out); end
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 0, 0, 0);
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_valid got %b want 0", inst_valid); end
    endtask

    task automatic test_sequential();
        do_reset();
        drive(1, 0, 0, 0);
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL seq_start_valid got %b want 0", inst_valid); end
        compared++; if (direccion !== 10'd0) begin mismatched++; $display("[TB] FAIL seq_start_dir got %0d want 0", direccion); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0);
            compared++; if (inst_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL seq_valid[%0d] got %b want 1", i, inst_valid); end
            compared++; if (pc_out !== 10'(i)) begin mismatched++; $display("[TB] FAIL seq_pc[%0d] got %0d want %0d", i, pc_out, i); end
            compared++; if (inst_out !== rom[i]) begin mismatched++; $display("[TB] FAIL seq_inst[%0d] got %h want %h", i, inst_out, rom[i]); end
        end
        drive(0, 0, 0, 0);
        compared++; if (instr_count !== 16'd4) begin mismatched++; $display("[TB] FAIL seq_count got %0d want 4", instr_count); end
        compared++; if (pc_out !== 10'd4) begin mismatched++; $display("[TB] FAIL seq_pc4 got %0d want 4", pc_out); end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0);
            compared++; if (pc_out !== 10'd2) begin mismatched++; $display("[TB] FAIL stall_pc[%0d] got %0d want 2", i, pc_out); end
            compared++; if (inst_out !== rom[2]) begin mismatched++; $display("[TB] FAIL stall_inst[%0d] got %h want %h", i, inst_out, rom[2]); end
            compared++; if (instr_count !== 16'd2) begin mismatched++; $display("[TB] FAIL stall_count[%0d] got %0d want 2", i, instr_count); end
            compared++; if (direccion !== 10'd2) begin mismatched++; $display("[TB] FAIL stall_dir[%0d] got %0d want 2", i, direccion); end
        end
        drive(0, 0, 0, 0);
        compared++; if (pc_out !== 10'd2 || inst_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_release got pc %0d v %b want pc 2 v 1", pc_out, inst_valid); end
        drive(0, 0, 0, 0);
        compared++; if (pc_out !== 10'd3) begin mismatched++; $display("[TB] FAIL stall_resume_pc got %0d want 3", pc_out); end
        compared++; if (instr_count !== 16'd3) begin mismatched++; $display("[TB] FAIL stall_resume_count got %0d want 3", instr_count); end
    endtask

    task automatic test_redirect();
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 10'd12);
        compared++; if (pc_out !== 10'd5) begin mismatched++; $display("[TB] FAIL redir_pc5 got %0d want 5", pc_out); end
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL redir_squash got %b want 0", inst_valid); end
        compared++; if (direccion !== 10'd12) begin mismatched++; $display("[TB] FAIL redir_dir got %0d want 12", direccion); end
        drive(0, 0, 0, 0);
        compared++; if (pc_out !== 10'd12 || inst_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL redir_target got pc %0d v %b want pc 12 v 1", pc_out, inst_valid); end
        compared++; if (inst_out !== rom[12]) begin mismatched++; $display("[TB] FAIL redir_inst got %h want %h", inst_out, rom[12]); end
        compared++; if (instr_count !== 16'd5) begin mismatched++; $display("[TB] FAIL redir_count got %0d want 5", instr_count); end
        drive(0, 1, 1, 10'd20);
        compared++; if (inst_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL redir_stall_valid got %b want 0", inst_valid); end
        compared++; if (direccion !== 10'd20) begin mismatched++; $display("[TB] FAIL redir_stall_dir got %0d want 20", direccion); end
        drive(0, 0, 0, 0);
        compared++; if (pc_out !== 10'd20 || inst_out !== rom[20]) begin mismatched++; $display("[TB] FAIL redir_stall_target got pc %0d inst %h want pc 20 inst %h", pc_out, inst_out, rom[20]); end
        compared++; if (instr_count !== 16'd6) begin mismatched++; $display("[TB] FAIL redir_stall_count got %0d want 6", instr_count); end
    endtask

    task automatic test_hlt();
        do_reset();
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 10'd14);
        drive(0, 0, 0, 0);
        compared++; if (pc_out !== 10'd14 || instr_count !== 16'd0) begin mismatched++; $display("[TB] FAIL hlt_pc14 got pc %0d cnt %0d want pc 14 cnt 0", pc_out, instr_count); end
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        compared++; if (inst_out !== 32'h1 || inst_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL hlt_present got inst %h v %b want 1 v 1", inst_out, inst_valid); end
        drive(0, 0, 0, 0);
        compared++; if (halted !== 1'b0 || pc_out !== 10'd16) begin mismatched++; $display("[TB] FAIL hlt_stalled got halted %b pc %0d want 0 16", halted, pc_out); end
        drive(0, 0, 0, 0);
        compared++; if (halted !== 1'b1) begin mismatched++; $display("[TB] FAIL hlt_halted got %b want 1", halted); end
        compared++; if (instr_count !== 16'd3) begin mismatched++; $display("[TB] FAIL hlt_count got %0d want 3", instr_count); end
        compared++; if (direccion !== 10'd0) begin mismatched++; $display("[TB] FAIL hlt_dir got %0d want 0", direccion); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0);
            compared++; if (inst_valid !== 1'b0 || halted !== 1'b1) begin mismatched++; $display("[TB] FAIL hlt_hold[%0d] got v %b h %b want 0 1", i, inst_valid, halted); end
        end
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        compared++; if (halted !== 1'b0 || inst_valid !== 1'b1 || pc_out !== 10'd0) begin mismatched++; $display("[TB] FAIL hlt_restart got h %b v %b pc %0d want 0 1 0", halted, inst_valid, pc_out); end
        compared++; if (instr_count !== 16'd0) begin mismatched++; $display("[TB] FAIL hlt_restart_count got %0d want 0", instr_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 10'd1023);
        drive(0, 0, 0, 0);
        compared++; if (pc_out !== 10'd1023 || inst_out !== rom[1023]) begin mismatched++; $display("[TB] FAIL wrap_1023 got pc %0d inst %h want 1023 %h", pc_out, inst_out, rom[1023]); end
        compared++; if (direccion !== 10'd0) begin mismatched++; $display("[TB] FAIL wrap_dir got %0d want 0", direccion); end
        drive(0, 0, 0, 0);
        compared++; if (pc_out !== 10'd0 || inst_valid !== 1'b1 || inst_out !== rom[0]) begin mismatched++; $display("[TB] FAIL wrap_0 got pc %0d v %b want 0 1", pc_out, inst_valid); end
    endtask

    task automatic test_async_reset();
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        compared++; if (inst_valid !== 1'b0 || pc_out !== 10'd0 || instr_count !== 16'd0 || halted !== 1'b0) begin mismatched++; $display("[TB] FAIL async_reset got v %b pc %0d cnt %0d h %b want 0 0 0 0", inst_valid, pc_out, instr_count, halted); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0);
            compared++; if (inst_valid !== 1'b0 || direccion !== 10'd0) begin mismatched++; $display("[TB] FAIL post_reset_idle[%0d] got v %b dir %0d want 0 0", i, inst_valid, direccion); end
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0220_0020 + (i << 11);
        rom[16] = 32'h0000_0001;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_hlt();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
